// File: rtl/compa_pkg.sv
// Shared definitions for the compa comparator and its binary-search initiator.
// Holds the FSM state type, the {l,e,g} flag encodings and the steps-width helper.
package compa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EVAL   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_GT = 3'b001;

    // A search over W bits takes at most W+1 comparisons, so the count spans 0..W+1.
    function automatic int steps_w(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/compa_search_ctrl.sv
// Binary-search initiator: drives the comparator's `a` operand and narrows [lo,hi]
// from the {l,e,g} response until the hidden `b` value is found or the flags contradict.
module compa_search_ctrl
    import compa_pkg::*;
#(
    parameter int W       = 4,
    parameter int CMP_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   cmp_l,
    input  logic                   cmp_e,
    input  logic                   cmp_g,
    output logic [W-1:0]           guess,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic                   err,
    output logic [W-1:0]           result,
    output logic [steps_w(W)-1:0]  steps
);

    localparam int SW = steps_w(W);
    localparam int CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

    localparam logic [W:0]    RANGE_MAX   = {1'b0, {W{1'b1}}};
    localparam logic [W-1:0]  FIRST_GUESS = RANGE_MAX[W:1];
    localparam logic [W:0]    ONE_X       = 1;
    localparam logic [SW-1:0] ONE_STEP    = 1;
    localparam logic [CW-1:0] CNT_ONE     = 1;
    localparam logic [CW-1:0] CNT_INIT    = CW'(CMP_LAT - 1);

    state_e        state_q, state_d;
    logic [W:0]    lo_q, lo_d;
    logic [W:0]    hi_q, hi_d;
    logic [W-1:0]  guess_q, guess_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] steps_q, steps_d;
    logic          found_q, found_d;
    logic          err_q, err_d;
    logic [W-1:0]  result_q, result_d;

    logic [2:0]    flags;
    logic [W:0]    guess_x;
    logic [W:0]    lo_up;
    logic [W:0]    hi_dn;
    logic [W:0]    sum_lt;
    logic [W:0]    sum_gt;

    // All range arithmetic is one bit wider than the operand so guess+1 and lo+hi never wrap.
    assign flags   = {cmp_l, cmp_e, cmp_g};
    assign guess_x = {1'b0, guess_q};
    assign lo_up   = guess_x + ONE_X;
    assign hi_dn   = guess_x - ONE_X;
    assign sum_lt  = lo_up + hi_q;
    assign sum_gt  = lo_q + hi_dn;

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        cnt_d    = cnt_q;
        steps_d  = steps_q;
        found_d  = found_q;
        err_d    = err_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = RANGE_MAX;
                    guess_d = FIRST_GUESS;
                    steps_d = '0;
                    found_d = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = CNT_INIT;
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_EVAL;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_EVAL: begin
                steps_d = steps_q + ONE_STEP;
                state_d = ST_DONE;
                case (flags)
                    CMP_EQ: begin
                        result_d = guess_q;
                        found_d  = 1'b1;
                    end
                    CMP_LT: begin
                        if (guess_q == {W{1'b1}}) begin
                            err_d = 1'b1;
                        end else begin
                            lo_d = lo_up;
                            if (lo_up > hi_q) begin
                                err_d = 1'b1;
                            end else begin
                                guess_d = sum_lt[W:1];
                                cnt_d   = CNT_INIT;
                                state_d = ST_SETTLE;
                            end
                        end
                    end
                    CMP_GT: begin
                        if (guess_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            hi_d = hi_dn;
                            if (lo_q > hi_dn) begin
                                err_d = 1'b1;
                            end else begin
                                guess_d = sum_gt[W:1];
                                cnt_d   = CNT_INIT;
                                state_d = ST_SETTLE;
                            end
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lo_q     <= '0;
            hi_q     <= RANGE_MAX;
            guess_q  <= '0;
            cnt_q    <= '0;
            steps_q  <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            cnt_q    <= cnt_d;
            steps_q  <= steps_d;
            found_q  <= found_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign guess  = guess_q;
    assign busy   = (state_q == ST_SETTLE) || (state_q == ST_EVAL);
    assign done   = (state_q == ST_DONE);
    assign found  = found_q;
    assign err    = err_q;
    assign result = result_q;
    assign steps  = steps_q;

endmodule

// File: tb/tb_compa_search_ctrl.sv
// Directed bench for compa_search_ctrl with an in-bench comparator and a
// range-halving reference model that predicts every cycle of each search.
module tb_compa_search_ctrl;

  localparam int W       = 4;
  localparam int CMP_LAT = 1;
  localparam int SW      = $clog2(W + 2);
  localparam int MAXV    = (1 << W) - 1;
  localparam int TB      = W + SW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic          cmp_l, cmp_e, cmp_g;
  logic [W-1:0]  guess, result;
  logic          busy, done, found, err;
  logic [SW-1:0] steps;

  int target     = 0;
  int fault_mode = 0;  // 0 honest, 1 stuck 000, 2 claims g when guess==0

  function automatic logic [2:0] flags_of(input int g, input int t, input int mode);
    logic [2:0] nat;
    nat = (g < t) ? 3'b100 : ((g == t) ? 3'b010 : 3'b001);
    case (mode)
      1:       return 3'b000;
      2:       return (g == 0) ? 3'b001 : nat;
      default: return nat;
    endcase
  endfunction

  assign {cmp_l, cmp_e, cmp_g} = flags_of(int'(guess), target, fault_mode);

  compa_search_ctrl #(.W(W), .CMP_LAT(CMP_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .cmp_l (cmp_l),
    .cmp_e (cmp_e),
    .cmp_g (cmp_g),
    .guess (guess),
    .busy  (busy),
    .done  (done),
    .found (found),
    .err   (err),
    .result(result),
    .steps (steps)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_guess[$];
  int m_n;
  bit m_found;
  bit m_err;
  int m_result = 0;

  task automatic model_search(input int t, input int mode);
    int lo, hi, g;
    logic [2:0] f;
    bit fin;
    lo = 0;
    hi = MAXV;
    fin = 0;
    m_found = 0;
    m_err = 0;
    m_guess.delete();
    while (!fin) begin
      g = (lo + hi) / 2;
      m_guess.push_back(g);
      f = flags_of(g, t, mode);
      if (f == 3'b010) begin
        m_found = 1; m_result = g; fin = 1;
      end else if (f == 3'b100) begin
        lo = g + 1;
        if (lo > hi) begin m_err = 1; fin = 1; end
      end else if (f == 3'b001) begin
        hi = g - 1;
        if (lo > hi) begin m_err = 1; fin = 1; end
      end else begin
        m_err = 1; fin = 1;
      end
    end
    m_n = m_guess.size();
  endtask

  // ---------------- scoreboard ----------------
  // entry: {busy, done, steps, guess}
  logic [TB+1:0] exp_q[$];
  int  fin_found, fin_err, fin_result;
  bit  chk_en = 0;

  task automatic push_trace();
    for (int k = 0; k < m_n; k++)
      for (int c = 0; c <= CMP_LAT; c++)
        exp_q.push_back({1'b1, 1'b0, SW'(k), W'(m_guess[k])});
    exp_q.push_back({1'b0, 1'b1, SW'(m_n), W'(m_guess[m_n-1])});
    fin_found  = m_found;
    fin_err    = m_err;
    fin_result = m_result;
  endtask

  always @(negedge clk) begin
    logic [TB+1:0] e;
    if (rst_n && chk_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy", busy, e[TB+1]);
        chk("done", done, e[TB]);
        chk("steps", steps, e[TB-1:W]);
        chk("guess", guess, e[W-1:0]);
        if (e[TB]) begin
          chk("found", found, fin_found);
          chk("err", err, fin_err);
          chk("result", result, fin_result);
          chk("steps_bound", int'(steps <= SW'(W + 1)), 1);
        end else begin
          chk("found_clear", found, 0);
          chk("err_clear", err, 0);
        end
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
      end
    end
  end

  // ---------------- driver ----------------
  int last_lat;

  task automatic run_search(input int t, input int mode, input bit rebounce);
    int lat, w;
    @(negedge clk); #1;
    target     = t;
    fault_mode = mode;
    model_search(t, mode);
    push_trace();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      start = rebounce && (lat == 2);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    last_lat = lat;
    chk("latency", lat, m_n * (CMP_LAT + 1) + 1);
    w = 0;
    while (exp_q.size() > 0 && w < 50) begin
      @(negedge clk); #1;
      w++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_err", err, 0);
    chk("rst_guess", guess, 0);
    chk("rst_result", result, 0);
    chk("rst_steps", steps, 0);
    @(negedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // pin the model with hand-derived guess sequences
    model_search(11, 0);
    chk("model_t11_n", m_n, 2);
    chk("model_t11_g0", m_guess[0], 7);
    chk("model_t11_g1", m_guess[1], 11);
    model_search(15, 0);
    chk("model_t15_n", m_n, 5);
    chk("model_t15_g3", m_guess[3], 14);
    chk("model_t15_g4", m_guess[4], 15);
    model_search(0, 0);
    chk("model_t0_n", m_n, 4);
    chk("model_t0_g2", m_guess[2], 1);
    model_search(5, 0);
    chk("model_t5_g1", m_guess[1], 3);
    chk("model_t5_g2", m_guess[2], 5);
    model_search(9, 1);
    chk("model_stuck_err", int'(m_err), 1);
    m_result = 0;

    run_search(11, 0, 0);
    chk("t11_latency_lit", last_lat, 5);
    chk("t11_result_lit", result, 11);
    chk("t11_steps_lit", steps, 2);

    run_search(0, 0, 0);
    chk("t0_result_lit", result, 0);
    chk("t0_steps_lit", steps, 4);

    run_search(15, 0, 0);
    chk("t15_result_lit", result, 15);
    chk("t15_steps_lit", steps, 5);

    run_search(9, 1, 0);
    chk("stuck_err_lit", err, 1);
    chk("stuck_found_lit", found, 0);
    chk("stuck_steps_lit", steps, 1);

    run_search(0, 2, 0);
    chk("gzero_err_lit", err, 1);
    chk("gzero_steps_lit", steps, 4);

    // reset in the SETTLE of the second comparison
    @(negedge clk); #1;
    target     = 13;
    fault_mode = 0;
    model_search(13, 0);
    push_trace();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_guess_lit", guess, 11);
    chk("mid_steps_lit", steps, 1);
    chk("mid_busy_lit", busy, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_guess", guess, 0);
    chk("arst_steps", steps, 0);
    chk("arst_found", found, 0);
    chk("arst_err", err, 0);
    chk("arst_result", result, 0);
    m_result = 0;
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;

    run_search(13, 0, 0);
    chk("t13_result_lit", result, 13);
    chk("t13_found_lit", found, 1);

    run_search(5, 0, 1);
    chk("t5_result_lit", result, 5);
    chk("t5_steps_lit", steps, 3);

    for (int t = 0; t <= MAXV; t++) begin
      run_search(t, 0, 0);
      chk("sweep_found", found, 1);
    end

    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
